demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter: WIDTH, 32, data width of the input and both outputs.
REQ-002 Parameter: DEPTH, 2, entries per output buffer (power of two, 2..16).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  source offers a word.
REQ-006 Port: in_ready  output  1  router accepts the offered word.
REQ-007 Port: in_data  input  WIDTH  offered word.
REQ-008 Port: in_sel  input  1  destination select: 0 routes to port A, 1 routes to port B.
REQ-009 Port: a_valid / b_valid  output  1  output port holds a word.
REQ-010 Port: a_data / b_data  output  WIDTH  head word of the output buffer.
REQ-011 Port: a_ready / b_ready  input  1  sink consumes the head word.

Function
REQ-012 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur with x_valid=1 and x_ready=1.
REQ-013 in_ready SHALL equal "occupancy of the buffer selected by in_sel < DEPTH"; it is combinational in in_sel only and SHALL NOT depend on a_ready/b_ready.
REQ-014 The source SHALL hold in_data and in_sel stable while in_valid=1 and in_ready=0; the router SHALL not require in_valid to stay high.
REQ-015 An accepted word SHALL be written to the selected buffer only; the other buffer SHALL be unchanged.
REQ-016 Latency: a word accepted at edge N SHALL be visible on x_valid/x_data after edge N; there is no same-cycle bypass.
REQ-017 Each buffer SHALL be FIFO-ordered; words routed to one port SHALL leave in acceptance order.
REQ-018 x_valid SHALL equal "occupancy > 0"; x_data SHALL be the head entry and SHALL hold stable while x_valid=1 and x_ready=0.
REQ-019 Simultaneous push and pop on one buffer SHALL leave occupancy unchanged and SHALL advance both pointers.
REQ-020 When a buffer is full, a same-cycle pop SHALL NOT make in_ready high for that buffer in that cycle.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH inclusive.
REQ-022 x_ready asserted while empty SHALL have no effect.
REQ-023 Ports A and B SHALL drain independently; a stalled port SHALL NOT block traffic to the other port.

Reset
REQ-024 While rst=1 at an edge: all pointers and occupancies SHALL be 0, a_valid=b_valid=0, and a_data=b_data=0.
REQ-025 Reset mid-operation SHALL discard all buffered words; no word accepted before reset SHALL appear after it.
REQ-026 During the reset cycle, in_ready SHALL evaluate from post-reset (empty) state on the next cycle; no transfer is recorded on the reset edge.

Configuration
REQ-027 Macro DEMUX_ROUTER_STATS_EN defined: the block SHALL add outputs a_count and b_count (32 bits each). Each counter increments by 1 per accepted input word for that port, wraps from 0xFFFFFFFF to 0, and resets to 0.
REQ-028 Macro DEMUX_ROUTER_STATS_EN undefined: the counter ports and logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-029 Shared package router_pkg SHALL hold the default WIDTH/DEPTH constants and the select encodings SEL_A=1'b0 and SEL_B=1'b1.
REQ-030 One sub-module, router_fifo (push/pop/full/empty/head, parameter WIDTH/DEPTH), SHALL be instantiated once per output port.

Verification
REQ-031 Reset, then send 0x11111111 (sel=0) and 0x22222222 (sel=1) with both readies high. Required: a_data=0x11111111 one cycle after acceptance, b_data=0x22222222 one cycle after its acceptance, and b_valid=0 while A carries data.
REQ-032 With a_ready=0, push 3 words to A (DEPTH=2). Required: in_ready goes 0 after the second word; a word with sel=1 is still accepted; after raising a_ready, A outputs the first two words in order.
REQ-033 With A full, assert a_ready and in_valid (sel=0) in the same cycle. Required: in_ready=0 in that cycle, and 1 in the next cycle.
REQ-034 Stream 10 words to B with b_ready=1 throughout. Required: one word per cycle, the pointers wrap correctly, the order is preserved, and occupancy never exceeds 1.
REQ-035 Fill both buffers, then assert rst for 1 cycle. Required: a_valid=b_valid=0, data=0, and in_ready=1 for both selects afterwards.
REQ-036 With DEMUX_ROUTER_STATS_EN defined, send 5 words to A and 3 words to B, then force a_count to 0xFFFFFFFF and send one word to A. Required: counts 5/3, then a_count wraps to 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the demux router: default geometry and select encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Destination select encodings carried on in_sel.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/router_fifo.sv
// Generic synchronous FIFO with power-of-two depth, used as one output buffer per port.
// Latency: a pushed word is visible on head the cycle after the push edge (no bypass).
// Backpressure: full is derived from registered occupancy only, so a same-cycle pop never frees a slot early.
module router_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Occupancy ranges 0..DEPTH, so the counter is one bit wider than the pointers.
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full && !rst;
    assign do_pop  = pop && !empty;

    // Head is masked while empty so stale storage never leaks onto the port after reset.
    assign head = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because head is masked by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/demux_router.sv
// One-input, two-output demux router with a FIFO per port; DEMUX_ROUTER_STATS_EN adds per-port accept counters.
// Latency: one cycle from input acceptance to the word appearing on the selected output.
// Backpressure: in_ready reflects only the selected buffer's registered fullness; a stalled port never blocks the other.
module demux_router
    import router_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
`ifdef DEMUX_ROUTER_STATS_EN
    ,
    output logic [31:0]      a_count,
    output logic [31:0]      b_count
`endif
);

    logic a_full;
    logic a_empty;
    logic b_full;
    logic b_empty;
    logic accept;
    logic a_push;
    logic b_push;

    // Readiness depends on the select and registered fullness only, never on the sink readies.
    assign in_ready = (in_sel == SEL_A) ? !a_full : !b_full;

    // Nothing is recorded on a reset edge.
    assign accept = in_valid && in_ready && !rst;
    assign a_push = accept && (in_sel == SEL_A);
    assign b_push = accept && (in_sel == SEL_B);

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;

    router_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_data (in_data),
        .pop       (a_ready),
        .full      (a_full),
        .empty     (a_empty),
        .head      (a_data)
    );

    router_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_data (in_data),
        .pop       (b_ready),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_data)
    );

`ifdef DEMUX_ROUTER_STATS_EN
    logic [31:0] a_cnt;
    logic [31:0] b_cnt;

    // Per-port accepted-word counters; they wrap silently at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (a_push) begin
                a_cnt <= a_cnt + 32'd1;
            end
            if (b_push) begin
                b_cnt <= b_cnt + 32'd1;
            end
        end
    end

    assign a_count = a_cnt;
    assign b_count = b_cnt;
`endif

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: routing, backpressure, full/pop interaction, streaming, reset flush, counters.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled 1-2 units after the edge.
// Backpressure: sink readies are driven explicitly per scenario.
module tb_demux_router;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
`ifdef DEMUX_ROUTER_STATS_EN
    logic [31:0]      a_count;
    logic [31:0]      b_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_router #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
`ifdef DEMUX_ROUTER_STATS_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %0b exp 0", a_valid); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %0b exp 0", b_valid); end
        checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL reset_a_data got %h exp 0", a_data); end
        checks++; if (b_data !== 32'h0) begin errors++; $display("FAIL reset_b_data got %h exp 0", b_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_a got %0b exp 1", in_ready); end
        in_sel = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_b got %0b exp 1", in_ready); end
        in_sel = 1'b0;
        tick();
    endtask

    task automatic test_basic_route();
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h1111_1111; in_sel = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b exp 1", in_ready); end
        tick();
        in_data = 32'h2222_2222; in_sel = 1'b1; #1;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL basic_a_valid got %0b exp 1", a_valid); end
        checks++; if (a_data !== 32'h1111_1111) begin errors++; $display("FAIL basic_a_data got %h exp 11111111", a_data); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL basic_b_idle got %0b exp 0", b_valid); end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_a_drained got %0b exp 0", a_valid); end
        checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL basic_b_valid got %0b exp 1", b_valid); end
        checks++; if (b_data !== 32'h2222_2222) begin errors++; $display("FAIL basic_b_data got %h exp 22222222", b_data); end
        tick();
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL basic_b_drained got %0b exp 0", b_valid); end
    endtask

    task automatic test_backpressure();
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA000_0001; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_w1 got %0b exp 1", in_ready); end
        tick();
        in_data = 32'hA000_0002; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_w2 got %0b exp 1", in_ready); end
        tick();
        in_data = 32'hA000_0003; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_w3 got %0b exp 0", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hB000_0001; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got %0b exp 1", in_ready); end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (b_data !== 32'hB000_0001) begin errors++; $display("FAIL bp_b_data got %h exp b0000001", b_data); end
        checks++; if (a_data !== 32'hA000_0001) begin errors++; $display("FAIL bp_a_head got %h exp a0000001", a_data); end
        a_ready = 1'b1;
        tick();
        checks++; if (a_data !== 32'hA000_0002) begin errors++; $display("FAIL bp_a_second got %h exp a0000002", a_data); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL bp_a_empty got %0b exp 0", a_valid); end
        a_ready = 1'b0; b_ready = 1'b1;
        tick();
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL bp_b_empty got %0b exp 0", b_valid); end
        b_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hC000_0001;
        tick();
        in_data = 32'hC000_0002;
        tick();
        a_ready = 1'b1; in_data = 32'hC000_0003; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_same_cycle got %0b exp 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_next_cycle got %0b exp 1", in_ready); end
        checks++; if (a_data !== 32'hC000_0002) begin errors++; $display("FAIL fullpop_head got %h exp c0000002", a_data); end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL fullpop_pushpop_valid got %0b exp 1", a_valid); end
        checks++; if (a_data !== 32'hC000_0003) begin errors++; $display("FAIL fullpop_pushpop_data got %h exp c0000003", a_data); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained got %0b exp 0", a_valid); end
        a_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] word;
        b_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            word = 32'hBEEF_0000 + WIDTH'(i);
            in_valid = 1'b1; in_sel = 1'b1; in_data = word; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %0b exp 1", i, in_ready); end
            tick();
            checks++; if (b_data !== word) begin errors++; $display("FAIL stream_data_%0d got %h exp %h", i, b_data, word); end
        end
        in_valid = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL stream_a_untouched got %0b exp 0", a_valid); end
        tick();
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %0b exp 0", b_valid); end
        b_ready = 1'b0;
    endtask

    task automatic test_reset_flush();
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = i[1]; in_data = 32'hD000_0000 + WIDTH'(i);
            tick();
        end
        in_sel = 1'b0; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_a got %0b exp 0", in_ready); end
        in_sel = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_b got %0b exp 0", in_ready); end
        rst = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; in_valid = 1'b0; #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL flush_a_valid got %0b exp 0", a_valid); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL flush_b_valid got %0b exp 0", b_valid); end
        checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL flush_a_data got %h exp 0", a_data); end
        checks++; if (b_data !== 32'h0) begin errors++; $display("FAIL flush_b_data got %h exp 0", b_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_a got %0b exp 1", in_ready); end
        in_sel = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_b got %0b exp 1", in_ready); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL flush_no_resurrect got %0b exp 0", a_valid); end
    endtask

`ifdef DEMUX_ROUTER_STATS_EN
    task automatic test_stats();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = (i >= 5); in_data = 32'h5000_0000 + WIDTH'(i);
            tick();
        end
        in_valid = 1'b0; #1;
        checks++; if (a_count !== 32'd5) begin errors++; $display("FAIL stats_a_count got %0d exp 5", a_count); end
        checks++; if (b_count !== 32'd3) begin errors++; $display("FAIL stats_b_count got %0d exp 3", b_count); end
        force dut.a_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.a_cnt;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h5000_00FF;
        tick();
        in_valid = 1'b0; #1;
        checks++; if (a_count !== 32'd0) begin errors++; $display("FAIL stats_a_wrap got %h exp 0", a_count); end
        checks++; if (b_count !== 32'd3) begin errors++; $display("FAIL stats_b_hold got %0d exp 3", b_count); end
        a_ready = 1'b0; b_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_route();
        test_backpressure();
        test_full_pop();
        test_stream();
        test_reset_flush();
`ifdef DEMUX_ROUTER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
